// File: rtl/hmac_dual_core_if.sv
// Command/result bundle between the HMAC register wrapper and hmac_dual_core.
interface hmac_dual_core_if;
  logic          zeroize;
  logic          init_cmd;
  logic          next_cmd;
  logic          mode;
  logic [511:0]  key;
  logic [1023:0] block_msg;
  logic          ready;
  logic          tag_valid;
  logic [511:0]  tag;
  logic          error;

  modport master (
    output zeroize, init_cmd, next_cmd, mode, key, block_msg,
    input  ready, tag_valid, tag, error
  );

  modport slave (
    input  zeroize, init_cmd, next_cmd, mode, key, block_msg,
    output ready, tag_valid, tag, error
  );
endinterface

// File: rtl/hmac_dual_core.sv
// Single-block HMAC-SHA-384/512 engine: H1 runs the inner hash,
// H2 the outer hash, sequenced by a small command FSM.
module sha512_core (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          zeroize,
  input  logic          init,
  input  logic          next,
  input  logic [1:0]    mode,
  input  logic [1023:0] block,
  output logic          ready,
  output logic [511:0]  digest
);
  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [511:0] IV384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  logic [63:0]  h_q [8];
  logic [63:0]  v_q [8];
  logic [63:0]  v_n [8];
  logic [63:0]  w_q [16];
  logic [63:0]  w_new;
  logic [63:0]  t1;
  logic [63:0]  t2;
  logic [6:0]   rnd_q;
  logic         busy_q;
  logic [511:0] iv;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign iv = (mode == 2'h2) ? IV384 : IV512;

  always_comb begin
    t1 = v_q[7]
       + (rotr(v_q[4], 14) ^ rotr(v_q[4], 18) ^ rotr(v_q[4], 41))
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + K[rnd_q] + w_q[0];
    t2 = (rotr(v_q[0], 28) ^ rotr(v_q[0], 34) ^ rotr(v_q[0], 39))
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    v_n[0] = t1 + t2;
    v_n[1] = v_q[0];
    v_n[2] = v_q[1];
    v_n[3] = v_q[2];
    v_n[4] = v_q[3] + t1;
    v_n[5] = v_q[4];
    v_n[6] = v_q[5];
    v_n[7] = v_q[6];
    // w_q is a sliding window over the schedule: w_q[0] is W[t]
    w_new = (rotr(w_q[14], 19) ^ rotr(w_q[14], 61) ^ (w_q[14] >> 6))
          + w_q[9]
          + (rotr(w_q[1], 1) ^ rotr(w_q[1], 8) ^ (w_q[1] >> 7))
          + w_q[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      rnd_q  <= '0;
      busy_q <= 1'b0;
    end else if (zeroize) begin
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      rnd_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      v_q <= v_n;
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new;
      rnd_q   <= rnd_q + 7'd1;
      if (rnd_q == 7'd79) begin
        busy_q <= 1'b0;
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_n[i];
      end
    end else if (init || next) begin
      for (int i = 0; i < 16; i++) w_q[i] <= block[1023-64*i -: 64];
      for (int i = 0; i < 8; i++) begin
        if (init) begin
          h_q[i] <= iv[511-64*i -: 64];
          v_q[i] <= iv[511-64*i -: 64];
        end else begin
          v_q[i] <= h_q[i];
        end
      end
      rnd_q  <= '0;
      busy_q <= 1'b1;
    end
  end

  assign ready  = !busy_q;
  assign digest = {h_q[0], h_q[1], h_q[2], h_q[3],
                   h_q[4], h_q[5], h_q[6], h_q[7]};
endmodule

module hmac_dual_core #(
  parameter int SUPPORT_512 = 1,
  parameter int BLOCK_W     = 1024
) (
  input logic            clk,
  input logic            reset_n,
  hmac_dual_core_if.slave bus
);
  if (BLOCK_W != 1024) begin : g_bad_block_w
    $error("hmac_dual_core: BLOCK_W must be 1024");
  end

  localparam logic [1023:0] IPAD_PAD = {128{8'h36}};
  localparam logic [1023:0] OPAD_PAD = {128{8'h5c}};

  typedef enum logic [2:0] {IDLE, IPAD, OPAD, HMAC, DONE} state_t;

  state_t        state_q;
  state_t        state_n;
  logic          wait_q;
  logic          mode_q;
  logic          sess_q;
  logic          tag_valid_q;
  logic          error_q;
  logic          take_init;
  logic          take_next;
  logic          bad_next;
  logic          issue;
  logic          h1_init, h1_next, h1_ready;
  logic          h2_init, h2_next, h2_ready;
  logic [1:0]    core_mode;
  logic [1023:0] kx;
  logic [1023:0] fin_blk;
  logic [1023:0] h1_block;
  logic [1023:0] h2_block;
  logic [511:0]  h1_digest;
  logic [511:0]  h2_digest;

  assign take_init = (state_q == IDLE) && !bus.zeroize && bus.init_cmd;
  assign take_next = (state_q == IDLE) && !bus.zeroize && !bus.init_cmd
                   && bus.next_cmd && sess_q;
  assign bad_next  = (state_q == IDLE) && !bus.zeroize && !bus.init_cmd
                   && bus.next_cmd && !sess_q;

  // wait_q is low only in the first (issue) cycle of a state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      wait_q  <= (state_n == state_q);
    end
  end

  always_comb begin
    state_n = state_q;
    if (bus.zeroize) begin
      state_n = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take_init)      state_n = IPAD;
          else if (take_next) state_n = OPAD;
        end
        IPAD: if (wait_q && h1_ready)             state_n = OPAD;
        OPAD: if (wait_q && h1_ready && h2_ready) state_n = HMAC;
        HMAC: if (wait_q && h2_ready)             state_n = DONE;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    issue   = !wait_q && !bus.zeroize;
    h1_init = 1'b0;
    h1_next = 1'b0;
    h2_init = 1'b0;
    h2_next = 1'b0;
    unique case (1'b1)
      state_q == IPAD: h1_init = issue;
      state_q == OPAD: begin
        h1_next = issue;
        h2_init = issue;
      end
      state_q == HMAC: h2_next = issue;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 1'b0;
      sess_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else if (bus.zeroize) begin
      mode_q      <= 1'b0;
      sess_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      error_q <= bad_next;
      if (take_init) begin
        mode_q      <= (SUPPORT_512 != 0) ? bus.mode : 1'b0;
        sess_q      <= 1'b1;
        tag_valid_q <= 1'b0;
      end else if (take_next) begin
        tag_valid_q <= 1'b0;
      end else if (state_q == DONE) begin
        tag_valid_q <= 1'b1;
      end
    end
  end

  assign core_mode = {1'b1, mode_q};
  assign kx = mode_q ? {bus.key, 512'b0}
                     : {bus.key[511:128], 640'b0};
  assign fin_blk = mode_q
    ? {h1_digest, 8'h80, 376'b0, 128'h600}
    : {h1_digest[511:128], 8'h80, 504'b0, 128'h580};

  assign h1_block = (state_q == IPAD) ? (kx ^ IPAD_PAD) : bus.block_msg;
  assign h2_block = (state_q == OPAD) ? (kx ^ OPAD_PAD) : fin_blk;

  sha512_core u_h1 (
    .clk     (clk),
    .reset_n (reset_n),
    .zeroize (bus.zeroize),
    .init    (h1_init),
    .next    (h1_next),
    .mode    (core_mode),
    .block   (h1_block),
    .ready   (h1_ready),
    .digest  (h1_digest)
  );

  sha512_core u_h2 (
    .clk     (clk),
    .reset_n (reset_n),
    .zeroize (bus.zeroize),
    .init    (h2_init),
    .next    (h2_next),
    .mode    (core_mode),
    .block   (h2_block),
    .ready   (h2_ready),
    .digest  (h2_digest)
  );

  assign bus.ready     = (state_q == IDLE);
  assign bus.tag_valid = tag_valid_q;
  assign bus.error     = error_q;
  assign bus.tag = !tag_valid_q ? '0
                 : mode_q ? h2_digest
                 : {h2_digest[511:128], 128'b0};
endmodule

// File: tb/tb_hmac_dual_core.sv
// Scoreboard bench for hmac_dual_core against a function-level
// HMAC-SHA-384/512 model plus RFC 4231 known answers.
module tb_hmac_dual_core;
  localparam logic [63:0] KT [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
  localparam logic [511:0] IV384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [511:0]  TC1_KEY = {{20{8'h0b}}, 352'b0};
  localparam logic [1023:0] TC1_BLK = {64'h4869205468657265, 8'h80, 824'b0, 128'h440};

  typedef struct {
    bit           is_err;
    logic [511:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t e;
  bit   ok;
  logic prev_tv = 1'b0;
  logic prev_err = 1'b0;

  logic [511:0] m_key;
  logic [511:0] m_inner;
  bit           m_mode;

  always #5 clk = ~clk;

  hmac_dual_core_if bus();

  hmac_dual_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] hs, input logic [1023:0] blk);
    logic [63:0] w [80];
    logic [63:0] a, b, c, d, f, g, h, ee, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[1023-64*t -: 64];
    for (int t = 16; t < 80; t++) begin
      s0 = rotr(w[t-15], 1) ^ rotr(w[t-15], 8) ^ (w[t-15] >> 7);
      s1 = rotr(w[t-2], 19) ^ rotr(w[t-2], 61) ^ (w[t-2] >> 6);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, ee, f, g, h} = hs;
    for (int t = 0; t < 80; t++) begin
      t1 = h + (rotr(ee, 14) ^ rotr(ee, 18) ^ rotr(ee, 41))
         + ((ee & f) ^ (~ee & g)) + KT[t] + w[t];
      t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39))
         + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = ee; ee = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hs[511:448] + a, hs[447:384] + b, hs[383:320] + c, hs[319:256] + d,
            hs[255:192] + ee, hs[191:128] + f, hs[127:64] + g, hs[63:0] + h};
  endfunction

  function automatic logic [1023:0] kx_of(input logic [511:0] k, input bit m);
    logic [1023:0] x;
    x = {k, 512'b0};
    if (!m) x[639:512] = '0;
    return x;
  endfunction

  function automatic logic [511:0] outer(input logic [511:0] inner,
                                         input logic [511:0] k, input bit m);
    logic [1023:0] fin;
    logic [511:0]  o;
    if (m) fin = {inner, 8'h80, 376'b0, 128'h600};
    else   fin = {inner[511:128], 8'h80, 504'b0, 128'h580};
    o = compress(compress(m ? IV512 : IV384, kx_of(k, m) ^ {128{8'h5c}}), fin);
    if (!m) o[127:0] = '0;
    return o;
  endfunction

  task automatic model_init(input logic [511:0] k, input bit m, input logic [1023:0] b);
    m_key   = k;
    m_mode  = m;
    m_inner = compress(compress(m ? IV512 : IV384, kx_of(k, m) ^ {128{8'h36}}), b);
    sb_q.push_back('{1'b0, outer(m_inner, m_key, m_mode)});
  endtask

  task automatic model_next(input logic [1023:0] b);
    m_inner = compress(m_inner, b);
    sb_q.push_back('{1'b0, outer(m_inner, m_key, m_mode)});
  endtask

  function automatic logic [511:0] r512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1023:0] r1024();
    return {r512(), r512()};
  endfunction

  task automatic do_cmd(input bit i, input bit n, input bit m,
                        input logic [511:0] k, input logic [1023:0] b);
    bus.init_cmd  = i;
    bus.next_cmd  = n;
    bus.mode      = m;
    bus.key       = k;
    bus.block_msg = b;
    @(negedge clk);
    bus.init_cmd = 1'b0;
    bus.next_cmd = 1'b0;
  endtask

  task automatic wait_tag(input string nm);
    int n;
    n = 0;
    while (!(bus.ready && bus.tag_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 512'(bus.ready && bus.tag_valid), 512'(1));
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (!bus.tag_valid) chk("tag_gated", bus.tag, '0);
      if (bus.tag_valid && !prev_tv) begin
        ok = (sb_q.size() != 0) && !sb_q[0].is_err;
        chk("tag_expected", 512'(ok), 512'(1));
        if (ok) begin
          e = sb_q.pop_front();
          chk("tag", bus.tag, e.tag);
        end
      end
      if (bus.error) begin
        chk("err_width", 512'(prev_err), '0);
        ok = (sb_q.size() != 0) && sb_q[0].is_err;
        chk("err_expected", 512'(ok), 512'(1));
        if (ok) e = sb_q.pop_front();
      end
    end
    prev_tv  = bus.tag_valid;
    prev_err = bus.error;
  end

  initial begin
    logic [511:0]  k;
    logic [1023:0] b;
    bit            m;
    bus.zeroize   = 1'b0;
    bus.init_cmd  = 1'b0;
    bus.next_cmd  = 1'b0;
    bus.mode      = 1'b0;
    bus.key       = '0;
    bus.block_msg = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(bus.ready), 512'(1));
    chk("rst_tag_valid", 512'(bus.tag_valid), '0);
    chk("rst_tag", bus.tag, '0);
    chk("rst_error", 512'(bus.error), '0);
    reset_n = 1'b1;
    @(negedge clk);

    sb_q.push_back('{1'b1, '0});
    do_cmd(1'b0, 1'b1, 1'b0, '0, '0);
    chk("nosess_error", 512'(bus.error), 512'(1));
    chk("nosess_ready", 512'(bus.ready), 512'(1));
    @(negedge clk);
    chk("nosess_err_drop", 512'(bus.error), '0);
    chk("nosess_ready2", 512'(bus.ready), 512'(1));
    chk("nosess_tv", 512'(bus.tag_valid), '0);

    model_init(TC1_KEY, 1'b0, TC1_BLK);
    do_cmd(1'b1, 1'b0, 1'b0, TC1_KEY, TC1_BLK);
    chk("init_ready_drop", 512'(bus.ready), '0);
    wait_tag("tc1_384_done");
    chk("tc1_384_hi", 512'(bus.tag[511:448]), 512'(64'hafd03944d8489562));
    chk("tc1_384_lo", 512'(bus.tag[127:0]), '0);

    b = r1024();
    model_next(b);
    do_cmd(1'b0, 1'b1, 1'b1, TC1_KEY, b);
    wait_tag("next_384_done");
    chk("next_384_lo", 512'(bus.tag[127:0]), '0);

    model_init(TC1_KEY, 1'b1, TC1_BLK);
    do_cmd(1'b1, 1'b0, 1'b1, TC1_KEY, TC1_BLK);
    wait_tag("tc1_512_done");
    chk("tc1_512_hi", 512'(bus.tag[511:448]), 512'(64'h87aa7cdea5ef619d));

    model_init(TC1_KEY, 1'b0, TC1_BLK);
    do_cmd(1'b1, 1'b1, 1'b0, TC1_KEY, TC1_BLK);
    chk("both_no_err", 512'(bus.error), '0);
    chk("both_busy", 512'(bus.ready), '0);
    wait_tag("both_done");
    chk("both_hi", 512'(bus.tag[511:448]), 512'(64'hafd03944d8489562));

    k = TC1_KEY;
    m = 1'b0;
    for (int it = 0; it < 8; it++) begin
      b = r1024();
      if (it == 0 || $urandom_range(0, 2) == 0) begin
        k = r512();
        m = 1'($urandom_range(0, 1));
        model_init(k, m, b);
        do_cmd(1'b1, 1'b0, m, k, b);
      end else begin
        model_next(b);
        do_cmd(1'b0, 1'b1, 1'($urandom_range(0, 1)), k, b);
      end
      bus.init_cmd = 1'b1;
      bus.next_cmd = 1'b1;
      bus.mode     = ~bus.mode;
      repeat (3) @(negedge clk);
      bus.init_cmd = 1'b0;
      bus.next_cmd = 1'b0;
      wait_tag("rand_done");
      if (!m) chk("rand_lo", 512'(bus.tag[127:0]), '0);
    end

    do_cmd(1'b1, 1'b0, 1'b1, k, b);
    repeat (120) @(negedge clk);
    chk("zero_busy", 512'(bus.ready), '0);
    bus.zeroize = 1'b1;
    @(negedge clk);
    bus.zeroize = 1'b0;
    chk("zero_ready", 512'(bus.ready), 512'(1));
    chk("zero_tv", 512'(bus.tag_valid), '0);
    chk("zero_tag", bus.tag, '0);
    chk("zero_no_err", 512'(bus.error), '0);
    sb_q.push_back('{1'b1, '0});
    do_cmd(1'b0, 1'b1, 1'b0, k, b);
    chk("zero_next_err", 512'(bus.error), 512'(1));
    repeat (200) @(negedge clk);
    chk("zero_still_idle", 512'(bus.tag_valid), '0);

    do_cmd(1'b1, 1'b0, 1'b0, k, b);
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 512'(bus.ready), 512'(1));
    chk("midrst_tv", 512'(bus.tag_valid), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb_q.push_back('{1'b1, '0});
    do_cmd(1'b0, 1'b1, 1'b0, k, b);
    chk("midrst_next_err", 512'(bus.error), 512'(1));

    repeat (5) @(negedge clk);
    chk("sb_empty", 512'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
